// File: rtl/fnd_pkg.sv
// Shared definitions for the FND scan driver: segment codes, edit-field
// encodings, conversion FSM states and field limits.
package fnd_pkg;

  // Active-low segments, bit order gfedcba.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [2:0] POS_HOUR = 3'b100;
  localparam logic [2:0] POS_MIN  = 3'b010;
  localparam logic [2:0] POS_SEC  = 3'b001;
  localparam logic [2:0] POS_NONE = 3'b000;

  localparam logic [4:0] HOUR_MAX   = 5'd23;
  localparam logic [5:0] MINSEC_MAX = 6'd59;

  // Any digit code above 9 decodes to a dash.
  localparam logic [3:0] DIGIT_DASH = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CONV_H = 3'd1,
    ST_CONV_M = 3'd2,
    ST_CONV_S = 3'd3,
    ST_COMMIT = 3'd4
  } state_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low 7-segment decoder; codes 10-15 show a dash.
module seg7_decode
  import fnd_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_DASH;
    case (i_digit)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/fnd_scan_driver.sv
// Converts binary hour/min/sec to tens/ones digits by repeated subtraction and
// time-multiplexes the six digits, tens on scan phase 0 and ones on phase 1.
module fnd_scan_driver
  import fnd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       scan_tick,
  input  logic       blink,
  input  logic       mode,
  input  logic [2:0] set_pos,
  input  logic [4:0] hour_in,
  input  logic [5:0] min_in,
  input  logic [5:0] sec_in,
  output logic       hourFNDSel2,
  output logic       hourFNDSel1,
  output logic       minFNDSel2,
  output logic       minFNDSel1,
  output logic       secFNDSel2,
  output logic       secFNDSel1,
  output logic [6:0] hourFND,
  output logic [6:0] minFND,
  output logic [6:0] secFND
);

  state_t     r_state;
  logic [4:0] r_snap_h;
  logic [5:0] r_snap_m;
  logic [5:0] r_snap_s;
  logic [5:0] r_work;
  logic [3:0] r_tens;
  logic [3:0] r_pend_h_t, r_pend_h_o, r_pend_m_t, r_pend_m_o, r_pend_s_t, r_pend_s_o;
  logic [3:0] r_dig_h_t, r_dig_h_o, r_dig_m_t, r_dig_m_o, r_dig_s_t, r_dig_s_o;
  logic       r_phase;

  logic       w_in_changed;
  logic       w_over;
  logic       w_done;
  logic [5:0] w_next_work;
  logic [3:0] w_res_t;
  logic [3:0] w_res_o;
  logic [6:0] w_seg_h_t, w_seg_h_o, w_seg_m_t, w_seg_m_o, w_seg_s_t, w_seg_s_o;
  logic       w_blank_h, w_blank_m, w_blank_s;

  assign w_in_changed = ({hour_in, min_in, sec_in} != {r_snap_h, r_snap_m, r_snap_s});

  // Range check of the field under conversion and the seed for the following field.
  always_comb begin
    w_over      = 1'b0;
    w_next_work = 6'd0;
    case (r_state)
      ST_CONV_H: begin
        w_over      = (r_snap_h > HOUR_MAX);
        w_next_work = r_snap_m;
      end
      ST_CONV_M: begin
        w_over      = (r_snap_m > MINSEC_MAX);
        w_next_work = r_snap_s;
      end
      ST_CONV_S: begin
        w_over      = (r_snap_s > MINSEC_MAX);
        w_next_work = 6'd0;
      end
      default: begin
        w_over      = 1'b0;
        w_next_work = 6'd0;
      end
    endcase
  end

  assign w_done  = w_over || (r_work < 6'd10);
  assign w_res_t = w_over ? DIGIT_DASH : r_tens;
  assign w_res_o = w_over ? DIGIT_DASH : r_work[3:0];

  // Conversion FSM; shown digits change only in COMMIT so fields never mix.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_snap_h   <= 5'd0;
      r_snap_m   <= 6'd0;
      r_snap_s   <= 6'd0;
      r_work     <= 6'd0;
      r_tens     <= 4'd0;
      r_pend_h_t <= 4'd0;
      r_pend_h_o <= 4'd0;
      r_pend_m_t <= 4'd0;
      r_pend_m_o <= 4'd0;
      r_pend_s_t <= 4'd0;
      r_pend_s_o <= 4'd0;
      r_dig_h_t  <= 4'd0;
      r_dig_h_o  <= 4'd0;
      r_dig_m_t  <= 4'd0;
      r_dig_m_o  <= 4'd0;
      r_dig_s_t  <= 4'd0;
      r_dig_s_o  <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_in_changed) begin
            r_snap_h <= hour_in;
            r_snap_m <= min_in;
            r_snap_s <= sec_in;
            r_work   <= {1'b0, hour_in};
            r_tens   <= 4'd0;
            r_state  <= ST_CONV_H;
          end
        end
        ST_CONV_H, ST_CONV_M, ST_CONV_S: begin
          if (!w_done) begin
            r_work <= r_work - 6'd10;
            r_tens <= r_tens + 4'd1;
          end else begin
            r_work <= w_next_work;
            r_tens <= 4'd0;
            case (r_state)
              ST_CONV_H: begin
                r_pend_h_t <= w_res_t;
                r_pend_h_o <= w_res_o;
                r_state    <= ST_CONV_M;
              end
              ST_CONV_M: begin
                r_pend_m_t <= w_res_t;
                r_pend_m_o <= w_res_o;
                r_state    <= ST_CONV_S;
              end
              ST_CONV_S: begin
                r_pend_s_t <= w_res_t;
                r_pend_s_o <= w_res_o;
                r_state    <= ST_COMMIT;
              end
              default: r_state <= ST_IDLE;
            endcase
          end
        end
        ST_COMMIT: begin
          r_dig_h_t <= r_pend_h_t;
          r_dig_h_o <= r_pend_h_o;
          r_dig_m_t <= r_pend_m_t;
          r_dig_m_o <= r_pend_m_o;
          r_dig_s_t <= r_pend_s_t;
          r_dig_s_o <= r_pend_s_o;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  seg7_decode u_dec_h_t (.i_digit(r_dig_h_t), .o_seg(w_seg_h_t));
  seg7_decode u_dec_h_o (.i_digit(r_dig_h_o), .o_seg(w_seg_h_o));
  seg7_decode u_dec_m_t (.i_digit(r_dig_m_t), .o_seg(w_seg_m_t));
  seg7_decode u_dec_m_o (.i_digit(r_dig_m_o), .o_seg(w_seg_m_o));
  seg7_decode u_dec_s_t (.i_digit(r_dig_s_t), .o_seg(w_seg_s_t));
  seg7_decode u_dec_s_o (.i_digit(r_dig_s_o), .o_seg(w_seg_s_o));

  // Non-one-hot set_pos never equals a field code, so it blanks nothing.
  assign w_blank_h = mode && blink && (set_pos == POS_HOUR);
  assign w_blank_m = mode && blink && (set_pos == POS_MIN);
  assign w_blank_s = mode && blink && (set_pos == POS_SEC);

  // Scan output registers; everything shown is sampled on the scan_tick cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase     <= 1'b0;
      hourFNDSel2 <= 1'b0;
      hourFNDSel1 <= 1'b0;
      minFNDSel2  <= 1'b0;
      minFNDSel1  <= 1'b0;
      secFNDSel2  <= 1'b0;
      secFNDSel1  <= 1'b0;
      hourFND     <= SEG_BLANK;
      minFND      <= SEG_BLANK;
      secFND      <= SEG_BLANK;
    end else if (scan_tick) begin
      r_phase     <= ~r_phase;
      hourFNDSel2 <= ~r_phase;
      hourFNDSel1 <= r_phase;
      minFNDSel2  <= ~r_phase;
      minFNDSel1  <= r_phase;
      secFNDSel2  <= ~r_phase;
      secFNDSel1  <= r_phase;
      hourFND     <= w_blank_h ? SEG_BLANK : (r_phase ? w_seg_h_o : w_seg_h_t);
      minFND      <= w_blank_m ? SEG_BLANK : (r_phase ? w_seg_m_o : w_seg_m_t);
      secFND      <= w_blank_s ? SEG_BLANK : (r_phase ? w_seg_s_o : w_seg_s_t);
    end
  end

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Self-checking bench for fnd_scan_driver: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a value-level model.
module tb_fnd_scan_driver;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scan_tick = 1'b0;
  logic       blink = 1'b0;
  logic       mode = 1'b0;
  logic [2:0] set_pos = 3'b000;
  logic [4:0] hour_in = 5'd0;
  logic [5:0] min_in = 6'd0;
  logic [5:0] sec_in = 6'd0;
  logic       hourFNDSel2, hourFNDSel1, minFNDSel2, minFNDSel1, secFNDSel2, secFNDSel1;
  logic [6:0] hourFND, minFND, secFND;

  int n_tests = 0;
  int n_fail  = 0;
  int n_print = 0;

  always #5 clk = ~clk;

  fnd_scan_driver dut (
    .clk(clk), .reset(reset), .scan_tick(scan_tick), .blink(blink), .mode(mode),
    .set_pos(set_pos), .hour_in(hour_in), .min_in(min_in), .sec_in(sec_in),
    .hourFNDSel2(hourFNDSel2), .hourFNDSel1(hourFNDSel1),
    .minFNDSel2(minFNDSel2), .minFNDSel1(minFNDSel1),
    .secFNDSel2(secFNDSel2), .secFNDSel1(secFNDSel1),
    .hourFND(hourFND), .minFND(minFND), .secFND(secFND)
  );

  function automatic logic [6:0] dig_seg(int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  function automatic logic [6:0] field_seg(int v, int vmax, bit ones, bit blank);
    if (blank) return 7'h7F;
    if (v > vmax) return 7'h3F;
    return dig_seg(ones ? (v % 10) : (v / 10));
  endfunction

  // Model: set of whole h/m/s values the display may legally show right now.
  // Any value applied within the last 44 cycles (or the one before it) is allowed;
  // once inputs are quiet for 44 cycles only the latest one is.
  int ch[8] = '{default: 0};
  int cm[8] = '{default: 0};
  int cs[8] = '{default: 0};
  int ncand = 1;
  int last_h = 0, last_m = 0, last_s = 0;
  int settle = 0;
  bit m_phase = 1'b0;
  bit e_sel2 = 1'b0, e_sel1 = 1'b0;
  logic [6:0] eh[8] = '{default: 7'h7F};
  logic [6:0] em[8] = '{default: 7'h7F};
  logic [6:0] es[8] = '{default: 7'h7F};
  int nexp = 1;

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      ncand = 1; ch[0] = 0; cm[0] = 0; cs[0] = 0;
      last_h = 0; last_m = 0; last_s = 0; settle = 0;
      m_phase = 1'b0; e_sel2 = 1'b0; e_sel1 = 1'b0;
      nexp = 1; eh[0] = 7'h7F; em[0] = 7'h7F; es[0] = 7'h7F;
    end else begin
      if (int'(hour_in) != last_h || int'(min_in) != last_m || int'(sec_in) != last_s) begin
        if (ncand == 8) begin
          for (int k = 0; k < 7; k++) begin
            ch[k] = ch[k+1]; cm[k] = cm[k+1]; cs[k] = cs[k+1];
          end
          ncand = 7;
        end
        last_h = int'(hour_in); last_m = int'(min_in); last_s = int'(sec_in);
        ch[ncand] = last_h; cm[ncand] = last_m; cs[ncand] = last_s;
        ncand++;
        settle = 0;
      end else if (settle < 1000) begin
        settle++;
      end
      if (settle >= 44 && ncand > 1) begin
        ch[0] = ch[ncand-1]; cm[0] = cm[ncand-1]; cs[0] = cs[ncand-1];
        ncand = 1;
      end
      if (scan_tick) begin
        for (int k = 0; k < ncand; k++) begin
          eh[k] = field_seg(ch[k], 23, m_phase, mode && blink && set_pos == 3'b100);
          em[k] = field_seg(cm[k], 59, m_phase, mode && blink && set_pos == 3'b010);
          es[k] = field_seg(cs[k], 59, m_phase, mode && blink && set_pos == 3'b001);
        end
        nexp   = ncand;
        e_sel2 = !m_phase;
        e_sel1 = m_phase;
        m_phase = !m_phase;
      end
    end
  end

  // Per-cycle comparison of the DUT against the model.
  initial forever begin
    bit ok_sel, ok_seg;
    @(negedge clk);
    ok_sel = ({hourFNDSel2, minFNDSel2, secFNDSel2} == {3{e_sel2}}) &&
             ({hourFNDSel1, minFNDSel1, secFNDSel1} == {3{e_sel1}});
    ok_seg = 1'b0;
    for (int k = 0; k < nexp; k++)
      if (hourFND == eh[k] && minFND == em[k] && secFND == es[k]) ok_seg = 1'b1;
    n_tests++;
    if (!(ok_sel && ok_seg)) begin
      n_fail++;
      if (n_print < 30) begin
        n_print++;
        $display("FAIL model_cmp t=%0t got sel2=%b%b%b sel1=%b%b%b seg=%h/%h/%h want sel2=%b sel1=%b seg=%h/%h/%h (of %0d)",
                 $time, hourFNDSel2, minFNDSel2, secFNDSel2, hourFNDSel1, minFNDSel1, secFNDSel1,
                 hourFND, minFND, secFND, e_sel2, e_sel1, eh[nexp-1], em[nexp-1], es[nexp-1], nexp);
      end
    end
  end

  task automatic chk7(input string name, input logic [6:0] got, input logic [6:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h want %h", name, got, exp);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %b want %b", name, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    scan_tick = 1'b1;
    @(negedge clk);
    scan_tick = 1'b0;
  endtask

  task automatic set_in(input int h, input int m, input int s);
    @(negedge clk);
    hour_in = h[4:0];
    min_in  = m[5:0];
    sec_in  = s[5:0];
  endtask

  // Shows one full scan (tens phase, then ones phase) and returns what was driven.
  task automatic scan_both(output logic [6:0] th, output logic [6:0] tm, output logic [6:0] ts,
                           output logic [6:0] oh, output logic [6:0] om, output logic [6:0] os);
    tick();
    if (!hourFNDSel2) tick();
    chk1("tens_phase_sel2", hourFNDSel2, 1'b1);
    th = hourFND; tm = minFND; ts = secFND;
    tick();
    chk1("ones_phase_sel1", hourFNDSel1, 1'b1);
    chk1("ones_phase_sel2_off", hourFNDSel2, 1'b0);
    oh = hourFND; om = minFND; os = secFND;
  endtask

  initial begin
    logic [6:0] th, tm, ts, oh, om, os;

    // Reset state
    repeat (3) @(negedge clk);
    chk1("rst_sel_all", |{hourFNDSel2, hourFNDSel1, minFNDSel2, minFNDSel1, secFNDSel2, secFNDSel1}, 1'b0);
    chk7("rst_hour", hourFND, 7'h7F);
    chk7("rst_min", minFND, 7'h7F);
    chk7("rst_sec", secFND, 7'h7F);
    reset = 1'b0;

    // First scan after release shows 00:00:00
    tick();
    chk1("first_sel2", hourFNDSel2, 1'b1);
    chk7("first_hour_tens", hourFND, 7'h40);
    tick();
    chk1("second_sel1", hourFNDSel1, 1'b1);
    chk7("second_hour_ones", hourFND, 7'h40);

    // 23:59:59 within 22 cycles
    set_in(23, 59, 59);
    repeat (22) @(negedge clk);
    scan_both(th, tm, ts, oh, om, os);
    chk7("t235959_h_t", th, 7'h24); chk7("t235959_m_t", tm, 7'h12); chk7("t235959_s_t", ts, 7'h12);
    chk7("t235959_h_o", oh, 7'h30); chk7("t235959_m_o", om, 7'h10); chk7("t235959_s_o", os, 7'h10);

    // Out-of-range hour
    set_in(25, 7, 42);
    repeat (22) @(negedge clk);
    scan_both(th, tm, ts, oh, om, os);
    chk7("oor_h_t", th, 7'h3F); chk7("oor_h_o", oh, 7'h3F);
    chk7("oor_m_t", tm, 7'h40); chk7("oor_m_o", om, 7'h78);
    chk7("oor_s_t", ts, 7'h19); chk7("oor_s_o", os, 7'h24);

    // Edit blinking of the minute field
    set_in(12, 34, 56);
    repeat (22) @(negedge clk);
    mode = 1'b1; set_pos = 3'b010; blink = 1'b1;
    scan_both(th, tm, ts, oh, om, os);
    chk7("blink_m_t", tm, 7'h7F); chk7("blink_m_o", om, 7'h7F);
    chk7("blink_h_t", th, 7'h79); chk7("blink_h_o", oh, 7'h24);
    chk7("blink_s_t", ts, 7'h12); chk7("blink_s_o", os, 7'h02);
    blink = 1'b0;
    scan_both(th, tm, ts, oh, om, os);
    chk7("blink_off_m_t", tm, 7'h30); chk7("blink_off_m_o", om, 7'h19);
    mode = 1'b0; blink = 1'b1;
    scan_both(th, tm, ts, oh, om, os);
    chk7("run_mode_m_t", tm, 7'h30); chk7("run_mode_m_o", om, 7'h19);
    blink = 1'b0; set_pos = 3'b000;

    // sec 09 -> 10 while the previous update is still converting
    set_in(1, 2, 9);
    repeat (3) @(negedge clk);
    hour_in = 5'd1; min_in = 6'd2; sec_in = 6'd10;
    scan_tick = 1'b1;
    repeat (44) @(negedge clk);
    scan_tick = 1'b0;
    scan_both(th, tm, ts, oh, om, os);
    chk7("chg_s_t", ts, 7'h79); chk7("chg_s_o", os, 7'h40);
    chk7("chg_h_t", th, 7'h40); chk7("chg_h_o", oh, 7'h79);
    chk7("chg_m_t", tm, 7'h40); chk7("chg_m_o", om, 7'h24);

    // Reset pulse in the middle of the minute conversion
    set_in(12, 34, 56);
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk7("midrst_hour", hourFND, 7'h7F);
    chk7("midrst_min", minFND, 7'h7F);
    chk1("midrst_sel", |{hourFNDSel2, hourFNDSel1, minFNDSel2, minFNDSel1, secFNDSel2, secFNDSel1}, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    scan_both(th, tm, ts, oh, om, os);
    chk7("postrst_h_t", th, 7'h40); chk7("postrst_m_t", tm, 7'h40); chk7("postrst_s_o", os, 7'h40);
    repeat (22) @(negedge clk);
    scan_both(th, tm, ts, oh, om, os);
    chk7("postrst_new_h_t", th, 7'h79); chk7("postrst_new_s_o", os, 7'h02);

    // Randomized traffic, checked by the model every cycle
    for (int it = 0; it < 60; it++) begin
      int hold;
      @(negedge clk);
      hour_in = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(24, 31)) : 5'($urandom_range(0, 23));
      min_in  = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(60, 63)) : 6'($urandom_range(0, 59));
      sec_in  = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(60, 63)) : 6'($urandom_range(0, 59));
      mode    = 1'($urandom_range(0, 1));
      set_pos = 3'($urandom_range(0, 7));
      hold = $urandom_range(20, 60);
      for (int c = 0; c < hold; c++) begin
        scan_tick = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 7) == 0) blink = ~blink;
        @(negedge clk);
      end
      scan_tick = 1'b0;
    end
    repeat (50) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fnd_scan_driver.md
FND_SCAN_DRIVER -- requirements
Module: fnd_scan_driver

Interface
REQ-001 The block SHALL have the following ports:
  clk  in  1  system clock, single clock domain.
  reset  in  1  asynchronous, active-high reset.
  scan_tick  in  1  one-cycle enable strobe at 100 Hz.
  blink  in  1  2 Hz square-wave level.
  mode  in  1  1 = time-set mode, 0 = run mode.
  set_pos  in  3  field under edit, one-hot: 100 hour, 010 min, 001 sec, 000 none.
  hour_in  in  5  binary hours, valid 0-23.
  min_in  in  6  binary minutes, valid 0-59.
  sec_in  in  6  binary seconds, valid 0-59.
  hourFNDSel2, hourFNDSel1, minFNDSel2, minFNDSel1, secFNDSel2, secFNDSel1  out  1 each  digit selects, active-high; Sel2 = tens, Sel1 = ones.
  hourFND, minFND, secFND  out  7 each  segments, active-low, bit order gfedcba.

Function
REQ-002 The block SHALL register a snapshot of hour_in/min_in/sec_in and start a conversion whenever any input differs from the snapshot while the FSM is in IDLE.
REQ-003 The conversion FSM SHALL have states IDLE, CONV_H, CONV_M, CONV_S, COMMIT, in that order, then return to IDLE.
REQ-004 Each CONV state SHALL compute tens/ones by repeated subtraction of 10, one subtraction per cycle, with at most 5 subtractions per field.
REQ-005 Input changes during a conversion SHALL be ignored until IDLE; the next conversion then picks them up.
REQ-006 Worst-case latency from input change to displayed value SHALL be at most 22 clk cycles.
REQ-007 Display digit registers SHALL update only in COMMIT, all three fields in the same cycle, so no partial value is ever shown.
REQ-008 An out-of-range field (hour >23, min or sec >59) SHALL display dash (7'h3F) on both of its digits.
REQ-009 A 1-bit scan phase SHALL toggle on each scan_tick.
  - Phase 0 drives all Sel2 outputs high with the tens segments.
  - Phase 1 drives all Sel1 outputs high with the ones segments.
REQ-010 Sel2 and Sel1 of a pair SHALL never be high in the same cycle.
REQ-011 Selects and segments SHALL be registered and change exactly one clk cycle after the scan_tick cycle.
REQ-012 When mode=1, blink=1 and the field's set_pos bit is 1, that field's segments SHALL be blank (7'h7F) while its select still scans.
REQ-013 When mode=0, blink and set_pos SHALL have no effect.
REQ-014 A blink or set_pos change SHALL take effect at the next scan_tick update, not mid-phase.
REQ-015 set_pos values that are not one-hot SHALL be treated as 000.
REQ-016 Segment codes SHALL be:
  - 0 = 40, 1 = 79, 2 = 24, 3 = 30, 4 = 19, 5 = 12, 6 = 02, 7 = 78, 8 = 00, 9 = 10 (hex).
  - dash = 3F, blank = 7F.

Reset
REQ-017 While reset=1, the block SHALL hold:
  - all selects = 0 and all segment outputs = 7'h7F;
  - phase = 0, FSM = IDLE;
  - snapshot and digit registers = 0.
REQ-018 Reset asserted mid-conversion SHALL abort the conversion with no COMMIT.
REQ-019 On the first scan_tick after reset release, the block SHALL display 00:00:00.

Structure
REQ-020 A shared package fnd_pkg SHALL hold:
  - the segment constants, including DASH and BLANK;
  - the set_pos one-hot encodings;
  - the FSM state enumeration.
REQ-021 A combinational sub-module seg7_decode SHALL map a 4-bit digit to segments and be instantiated six times (tens and ones for each field).

Verification
REQ-022 The bench SHALL cover at least these directed scenarios:
  - Reset, release, one scan_tick: hourFNDSel2 = 1, hourFND = 7'h40; next tick: hourFNDSel1 = 1, hourFND = 7'h40.
  - Inputs 23/59/59, wait 22 cycles, scan: phase 0 shows segments 24/12/12, phase 1 shows 30/10/10.
  - hour_in = 25, other fields valid: hourFND = 7'h3F on both phases, min/sec fields correct.
  - mode = 1, set_pos = 010, blink toggling: minFND = 7'h7F while blink = 1, digits shown while blink = 0; hour and sec unaffected.
  - sec_in changes 09 -> 10 mid-conversion of a prior update: the display never shows a mixed value and settles to 10 within 44 cycles.
  - Reset pulsed during CONV_M: outputs = 7'h7F immediately, no COMMIT, then 00:00:00 after release.
